gray_decode_scheduler: RTL
==========================

GRAY_DECODE_SCHEDULER -- requirements
Module: gray_decode_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of each Gray word and binary result.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal 2..8).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester conversion request.
REQ-006 req_gray  input  NUM_REQ*DATA_WIDTH  packed Gray words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req_ready  output  NUM_REQ  one-hot grant; a request is accepted on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_bin  output  DATA_WIDTH  binary equivalent of the accepted Gray word.
REQ-011 out_id  output  clog2(NUM_REQ)  index of the requester that owns out_bin.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 The controller SHALL use an FSM with states IDLE, CONV and DONE.
REQ-014 In IDLE, req_ready SHALL be combinational and SHALL be one-hot on the round-robin winner among asserted req_valid bits, or all-zero if none are asserted.
REQ-015 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ and wrap through NUM_REQ-1 back to 0.
REQ-016 On acceptance, the block SHALL latch the winner's Gray word and index, update last_grant to the winner, and go to CONV.
REQ-017 req_ready SHALL be all-zero in CONV and DONE; requesters hold req_valid and req_gray until they are granted.
REQ-018 CONV SHALL resolve one bit per cycle, MSB first, from a down-counter k running from DATA_WIDTH-1 to 0: bin[DATA_WIDTH-1] = gray[DATA_WIDTH-1], and bin[k] = bin[k+1] XOR gray[k].
REQ-019 CONV SHALL last exactly DATA_WIDTH cycles, then go to DONE.
REQ-020 Latency: for an acceptance at edge T, out_valid SHALL rise at edge T+DATA_WIDTH+1.
REQ-021 In DONE, out_valid SHALL be 1, and out_bin and out_id SHALL stay stable until a cycle where out_ready is 1.
REQ-022 On that out_ready cycle, the FSM SHALL go to IDLE and out_valid SHALL fall at the next edge.
REQ-023 No new request SHALL be granted in the same cycle as result handoff; the next grant SHALL occur at the earliest in the following IDLE cycle.
REQ-024 out_bin and out_id SHALL hold their last values while out_valid is 0.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 A requester that deasserts req_valid before being granted SHALL be skipped with no side effect.

Reset
REQ-027 While reset is 1, at each rising edge the block SHALL set: FSM to IDLE, out_valid 0, out_bin 0, out_id 0, busy 0, bit counter 0, and last_grant NUM_REQ-1, so requester 0 wins first.
REQ-028 While reset is 1, req_ready SHALL be forced to all-zero.
REQ-029 Reset asserted in CONV or DONE SHALL discard the in-flight word; no out_valid SHALL appear for it.

Configuration
REQ-030 When macro GRAY_DECODE_FAST_EN is defined, CONV SHALL be bypassed and the full conversion (bin[i] = XOR of gray[DATA_WIDTH-1:i]) SHALL be computed in the acceptance cycle, giving IDLE -> DONE and out_valid at edge T+1.
REQ-031 When GRAY_DECODE_FAST_EN is undefined, the bit-serial CONV path of REQ-018 to REQ-020 SHALL apply.
REQ-032 All other behaviour, including arbitration, handshakes and reset, SHALL be identical with and without GRAY_DECODE_FAST_EN.

Verification
REQ-033 Serial single request: req 0, req_gray=16'h8000 -> out_bin=16'hFFFF, out_id=0, out_valid 17 cycles after acceptance.
REQ-034 Serial values: req 2, gray 16'hC000 -> out_bin 16'h8000; gray 16'h0001 -> 16'h0001; gray 16'h0000 -> 16'h0000, each with out_id=2.
REQ-035 Fairness: all four req_valid held high from reset release, out_ready=1 -> grants in order 0,1,2,3,0, one per conversion, with out_id matching each grant.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_bin and out_id stable; req_ready all-zero; single handoff when out_ready=1.
REQ-037 Reset abort: reset for 1 cycle at CONV cycle 8 -> IDLE, outputs zero, no result for the aborted word; next grant goes to requester 0.
REQ-038 Fast mode (GRAY_DECODE_FAST_EN defined): gray 16'h8000 accepted at edge T -> out_valid with out_bin=16'hFFFF at edge T+1.

Source files
------------

// File: rtl/gray_decode_scheduler_if.sv
// Request/result bundle for gray_decode_scheduler: NUM_REQ Gray-word requesters
// in, one binary result with owner index out.
interface gray_decode_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_gray;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_bin;
    logic [ID_W-1:0]               out_id;

    modport master (
        output req_valid, req_gray, out_ready,
        input  req_ready, out_valid, out_bin, out_id
    );

    modport slave (
        input  req_valid, req_gray, out_ready,
        output req_ready, out_valid, out_bin, out_id
    );
endinterface

// File: rtl/gray_decode_scheduler.sv
// Round-robin arbiter feeding a Gray-to-binary converter (IDLE/CONV/DONE).
// Bit-serial by default; define GRAY_DECODE_FAST_EN for single-cycle conversion.
module gray_decode_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    gray_decode_scheduler_if.slave bus,
    output logic                   busy
);
    localparam int          ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR_U = NUM_REQ;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] out_bin_q, out_bin_d;
    logic [ID_W-1:0]       out_id_q, out_id_d;
`ifndef GRAY_DECODE_FAST_EN
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

    logic                  hi_found, lo_found, win_found;
    logic [ID_W-1:0]       hi_idx, lo_idx, win_idx;
    logic [DATA_WIDTH-1:0] hi_gray, lo_gray, win_gray;
    logic [NUM_REQ-1:0]    grant;

    // Winner is the lowest valid index above last_grant, else the lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_gray  = '0;
        lo_gray  = '0;
        for (int unsigned i = 0; i < NR_U; i++) begin
            if (bus.req_valid[i] && !hi_found && (ID_W'(i) > last_grant_q)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
                hi_gray  = bus.req_gray[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (bus.req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                lo_gray  = bus.req_gray[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx  : lo_idx;
        win_gray  = hi_found ? hi_gray : lo_gray;
    end

    always_comb begin
        grant = '0;
        if ((state_q == IDLE) && !reset && win_found)
            grant[win_idx] = 1'b1;
    end

`ifdef GRAY_DECODE_FAST_EN
    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++)
            b[i] = ^(g >> i);
        return b;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_bin_d    = out_bin_q;
        out_id_d     = out_id_q;
`ifndef GRAY_DECODE_FAST_EN
        cnt_d        = cnt_q;
        gray_d       = gray_q;
        acc_d        = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    last_grant_d = win_idx;
`ifdef GRAY_DECODE_FAST_EN
                    out_bin_d    = gray2bin(win_gray);
                    out_id_d     = win_idx;
                    state_d      = DONE;
`else
                    gray_d       = win_gray;
                    acc_d        = '0;
                    cnt_d        = CNT_W'(DATA_WIDTH - 1);
                    state_d      = CONV;
`endif
                end
            end
`ifndef GRAY_DECODE_FAST_EN
            CONV: begin
                // acc shifts left with bin[k+1] in its LSB (0 before the MSB step),
                // so after DATA_WIDTH steps it holds the full binary word.
                acc_d = {acc_q[DATA_WIDTH-2:0], acc_q[0] ^ gray_q[cnt_q]};
                if (cnt_q == '0) begin
                    out_bin_d = acc_d;
                    out_id_d  = last_grant_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            out_bin_q    <= '0;
            out_id_q     <= '0;
`ifndef GRAY_DECODE_FAST_EN
            cnt_q        <= '0;
            gray_q       <= '0;
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_bin_q    <= out_bin_d;
            out_id_q     <= out_id_d;
`ifndef GRAY_DECODE_FAST_EN
            cnt_q        <= cnt_d;
            gray_q       <= gray_d;
            acc_q        <= acc_d;
`endif
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
    assign busy          = (state_q != IDLE);
endmodule
